bus_op_controller: RTL and testbench
====================================

Name: bus_op_controller

Overview:
- Sequencer for the shared tri-state register bus: an external Data driver plus NREG registers, each with an Rin load enable and an Rout bus-drive enable.
- Accepts one instruction at a time through a Run/Ready handshake.
- Decodes load, move and swap instructions into cycle-by-cycle Extern/Rout/Rin strobes, then signals Done/Error.
- The highest-numbered register, S = NREG-1, is reserved as swap scratch.

Parameters:
- NREG, 4, number of bus registers; must be a power of 2, minimum 4.
- AW, 2, register index width, log2(NREG).
- CW, 8, width of the completed-operation counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  instruction valid.
- IR  in  2+2*AW  instruction: IR[2*AW+1:2*AW]=op, IR[2*AW-1:AW]=X (destination/first), IR[AW-1:0]=Y (source/second).
- Ready  out  1  controller idle; Run is accepted this cycle.
- Extern  out  1  enables the external Data driver onto the bus.
- Rout  out  NREG  one-hot (or zero) register bus-drive enables.
- Rin  out  NREG  one-hot (or zero) register load enables.
- Done  out  1  final cycle of the instruction.
- Error  out  1  instruction rejected; valid only while Done=1.
- OpCount  out  CW  count of successfully completed instructions.

Behaviour:
- FSM states: IDLE, T1, T2, T3. Ready = (state==IDLE).
- All of Extern, Rout, Rin, Done and Error are Moore decodes of state and the latched instruction. All are 0 in IDLE.
- IDLE with Run=1: latch IR into an internal register, go to T1. Run is ignored in every non-IDLE state, including the Done cycle.
- op 00, ld Rx: T1 drives Extern=1, Rin[X]=1, Done=1, then returns to IDLE. Latency is 1 cycle after acceptance.
- op 01, mv Rx,Ry: T1 drives Rout[Y]=1, Rin[X]=1, Done=1, then returns to IDLE. X==Y is legal and performs a harmless self-copy.
- op 10, swap Rx,Ry:
  - T1: Rout[X], Rin[S].
  - T2: Rout[Y], Rin[X].
  - T3: Rout[S], Rin[Y], Done, then IDLE.
- Swap is illegal if X==Y, X==S or Y==S. An illegal swap produces T1 with Done=1, Error=1, no Extern/Rout/Rin, then IDLE.
- op 11 (reserved): T1 with Done=1, Error=1, no bus activity, then IDLE.
- Bus invariant: in every cycle at most one of {Extern, Rout[*]} is 1, and Rin has at most one bit set.
- OpCount increments by 1 on the edge ending a cycle with Done=1 and Error=0. Error completions do not count. Wraps (2^CW-1) -> 0.
- Back-to-back: Run held high yields a new acceptance in the IDLE cycle following each Done. Instruction period is latency+1 cycles: ld/mv every 2 cycles, swap every 4 cycles.
- Reset: on a clock edge with Reset=1, the state goes to IDLE, the latched IR clears to 0 and OpCount clears to 0. Reset has priority over Run.
- Reset mid-swap aborts immediately. No further strobes are issued; register contents may be left partially swapped, and that is acceptable. OpCount is cleared.
- The latched IR is the only source for decode. IR changing after acceptance has no effect.

Test Plan:
- Reset held 2 cycles, then released with Run=0 -> Ready=1, Extern=Rout=Rin=0, Done=0, OpCount=0.
- Run=1 with ld R1 (op00,X=1) for one cycle -> next cycle Extern=1, Rin=4'b0010, Done=1, Error=0; following cycle Ready=1, OpCount=1.
- swap R0,R2 with NREG=4 -> T1 Rout=0001/Rin=1000; T2 Rout=0100/Rin=0001; T3 Rout=1000/Rin=0100 with Done=1; OpCount +1. A bench regfile model loaded with R0=0x5A, R2=0xC3 ends with R0=0xC3, R2=0x5A.
- swap R1,R1, swap R0,R3 and op11 -> each gives a single T1 cycle with Done=1, Error=1, Rin=Rout=0, Extern=0; OpCount unchanged.
- Run held high with IR toggled mid-instruction; 255 consecutive mv ops followed by one more -> each op uses the IR value latched at acceptance, one acceptance per 2 cycles, and OpCount wraps 255->0.
- Reset asserted in T2 of a swap -> next cycle state is IDLE, all strobes 0, OpCount=0; a Run issued in the same cycle as Reset is ignored.

Source files
------------

// File: rtl/bus_op_controller.sv
// Instruction sequencer for a shared tri-state register bus.
// Turns ld/mv/swap instructions into per-cycle Extern/Rout/Rin strobes.
module bus_op_controller #(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2,
  parameter int unsigned CW   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [2*AW+1:0]   IR,
  output logic              Ready,
  output logic              Extern,
  output logic [NREG-1:0]   Rout,
  output logic [NREG-1:0]   Rin,
  output logic              Done,
  output logic              Error,
  output logic [CW-1:0]     OpCount
);

  localparam int unsigned IRW = 2*AW + 2;
  localparam logic [AW-1:0] SCRATCH = AW'(NREG - 1);

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_MV   = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IRW-1:0]  ir_q;
  logic [1:0]      op;
  logic [AW-1:0]   x_idx;
  logic [AW-1:0]   y_idx;
  logic            swap_bad;

  assign op    = ir_q[2*AW+1:2*AW];
  assign x_idx = ir_q[2*AW-1:AW];
  assign y_idx = ir_q[AW-1:0];

  // A swap needs two distinct operands, neither of which is the scratch register.
  assign swap_bad = (x_idx == y_idx) || (x_idx == SCRATCH) || (y_idx == SCRATCH);

  // State, latched instruction and completion counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      OpCount <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && Run) begin
        ir_q <= IR;
      end
      if (Done && !Error) begin
        OpCount <= OpCount + CW'(1);
      end
    end
  end

  // Next state and Moore strobe decode from state and latched instruction.
  always_comb begin
    state_d = state_q;
    Ready   = 1'b0;
    Extern  = 1'b0;
    Rout    = '0;
    Rin     = '0;
    Done    = 1'b0;
    Error   = 1'b0;

    case (state_q)
      IDLE: begin
        Ready = 1'b1;
        if (Run) begin
          state_d = T1;
        end
      end

      T1: begin
        state_d = IDLE;
        case (op)
          OP_LD: begin
            Extern = 1'b1;
            Rin    = NREG'(1) << x_idx;
            Done   = 1'b1;
          end
          OP_MV: begin
            Rout = NREG'(1) << y_idx;
            Rin  = NREG'(1) << x_idx;
            Done = 1'b1;
          end
          OP_SWAP: begin
            if (swap_bad) begin
              Done  = 1'b1;
              Error = 1'b1;
            end else begin
              Rout    = NREG'(1) << x_idx;
              Rin     = NREG'(1) << SCRATCH;
              state_d = T2;
            end
          end
          default: begin
            Done  = 1'b1;
            Error = 1'b1;
          end
        endcase
      end

      T2: begin
        Rout    = NREG'(1) << y_idx;
        Rin     = NREG'(1) << x_idx;
        state_d = T3;
      end

      T3: begin
        Rout    = NREG'(1) << SCRATCH;
        Rin     = NREG'(1) << y_idx;
        Done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_op_controller.sv
// Directed self-checking bench for bus_op_controller with a small regfile model.
module tb_bus_op_controller;

  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned CW   = 8;

  logic            Clock;
  logic            Reset;
  logic            Run;
  logic [5:0]      IR;
  logic            Ready;
  logic            Extern;
  logic [3:0]      Rout;
  logic [3:0]      Rin;
  logic            Done;
  logic            Error;
  logic [7:0]      OpCount;

  logic [7:0]      data;
  logic [7:0]      regs [4];
  logic [7:0]      bus;

  int n_checks = 0;
  int n_errors = 0;

  bus_op_controller #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .IR      (IR),
    .Ready   (Ready),
    .Extern  (Extern),
    .Rout    (Rout),
    .Rin     (Rin),
    .Done    (Done),
    .Error   (Error),
    .OpCount (OpCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register file fed by the shared bus.
  always_comb begin
    bus = Extern ? data : 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (Rout[i]) bus = bus | regs[i];
    end
  end

  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (Rin[i]) regs[i] <= bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] mk(input logic [1:0] op, input logic [1:0] x, input logic [1:0] y);
    return {op, x, y};
  endfunction

  // Check the bus invariant for the current cycle, then advance one clock.
  task automatic tick();
    int drivers;
    drivers = int'(Extern) + $countones(Rout);
    check("bus_drivers_le1", 32'(drivers <= 1), 32'd1);
    check("rin_le1", 32'($countones(Rin) <= 1), 32'd1);
    @(posedge Clock);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ext, input logic [3:0] ro,
                               input logic [3:0] ri, input logic dn, input logic er);
    check({tag, "_extern"}, 32'(Extern), 32'(ext));
    check({tag, "_rout"},   32'(Rout),   32'(ro));
    check({tag, "_rin"},    32'(Rin),    32'(ri));
    check({tag, "_done"},   32'(Done),   32'(dn));
    check({tag, "_error"},  32'(Error),  32'(er));
  endtask

  task automatic do_ld(input logic [1:0] x, input logic [7:0] val, input logic [7:0] cnt_after);
    IR = mk(2'b00, x, 2'd0); data = val; Run = 1'b1;
    tick();
    Run = 1'b0;
    check_strobes("ld_t1", 1'b1, 4'b0000, 4'b0001 << x, 1'b1, 1'b0);
    check("ld_t1_ready", 32'(Ready), 32'd0);
    tick();
    check("ld_ready", 32'(Ready), 32'd1);
    check("ld_opcount", 32'(OpCount), 32'(cnt_after));
    check("ld_reg", 32'(regs[x]), 32'(val));
  endtask

  initial begin
    logic [1:0] xs, ys;
    Reset = 1'b1; Run = 1'b0; IR = '0; data = '0;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;

    // Reset held two cycles.
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("rst_ready", 32'(Ready), 32'd1);
    check_strobes("rst", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("rst_opcount", 32'(OpCount), 32'd0);

    // Loads: R1, then R0=5A, R2=C3.
    do_ld(2'd1, 8'h11, 8'd1);
    do_ld(2'd0, 8'h5A, 8'd2);
    do_ld(2'd2, 8'hC3, 8'd3);

    // swap R0,R2; IR is scrambled after acceptance.
    IR = mk(2'b10, 2'd0, 2'd2); Run = 1'b1;
    tick();
    Run = 1'b0; IR = mk(2'b00, 2'd3, 2'd3);
    check_strobes("sw_t1", 1'b0, 4'b0001, 4'b1000, 1'b0, 1'b0);
    tick();
    check_strobes("sw_t2", 1'b0, 4'b0100, 4'b0001, 1'b0, 1'b0);
    tick();
    check_strobes("sw_t3", 1'b0, 4'b1000, 4'b0100, 1'b1, 1'b0);
    tick();
    check("sw_ready", 32'(Ready), 32'd1);
    check("sw_opcount", 32'(OpCount), 32'd4);
    check("sw_r0", 32'(regs[0]), 32'hC3);
    check("sw_r2", 32'(regs[2]), 32'h5A);

    // Rejected instructions: swap R1,R1 / swap R0,R3 / reserved op.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       IR = mk(2'b10, 2'd1, 2'd1);
        1:       IR = mk(2'b10, 2'd0, 2'd3);
        default: IR = mk(2'b11, 2'd0, 2'd1);
      endcase
      Run = 1'b1;
      tick();
      Run = 1'b0;
      check_strobes($sformatf("err%0d", k), 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1);
      tick();
      check($sformatf("err%0d_ready", k), 32'(Ready), 32'd1);
      check($sformatf("err%0d_opcount", k), 32'(OpCount), 32'd4);
    end

    // Clear the counter, then 256 back-to-back moves with Run held high.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst2_opcount", 32'(OpCount), 32'd0);
    Run = 1'b1;
    for (int i = 0; i < 256; i++) begin
      xs = 2'(i); ys = 2'(i >> 2);
      IR = mk(2'b01, xs, ys);
      check("b2b_ready", 32'(Ready), 32'd1);
      if (i == 255) check("b2b_cnt255", 32'(OpCount), 32'd255);
      tick();
      IR = mk(2'b10, ~xs, ys ^ 2'd1);
      check_strobes("b2b_t1", 1'b0, 4'b0001 << ys, 4'b0001 << xs, 1'b1, 1'b0);
      check("b2b_t1_ready", 32'(Ready), 32'd0);
      tick();
    end
    Run = 1'b0;
    check("b2b_wrap", 32'(OpCount), 32'd0);
    check("b2b_end_ready", 32'(Ready), 32'd1);

    // Reset in T2 of a swap, with Run asserted alongside it.
    do_ld(2'd1, 8'h77, 8'd1);
    IR = mk(2'b10, 2'd1, 2'd0); Run = 1'b1;
    tick();
    Run = 1'b0;
    check_strobes("ab_t1", 1'b0, 4'b0010, 4'b1000, 1'b0, 1'b0);
    tick();
    check_strobes("ab_t2", 1'b0, 4'b0001, 4'b0010, 1'b0, 1'b0);
    Reset = 1'b1; Run = 1'b1; IR = mk(2'b00, 2'd2, 2'd0);
    tick();
    Reset = 1'b0; Run = 1'b0;
    check("ab_ready", 32'(Ready), 32'd1);
    check_strobes("ab_idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("ab_opcount", 32'(OpCount), 32'd0);
    tick();
    check("ab_ready2", 32'(Ready), 32'd1);
    check_strobes("ab_idle2", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
